// File: rtl/compare_arbiter.sv
// compare_arbiter: round-robin arbiter sharing one registered unsigned magnitude comparator.
module compare_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int W = 2,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*W-1:0]  req_a,
  input  logic [NUM_REQ*W-1:0]  req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [ID_W-1:0]       rsp_id,
  output logic                  rsp_a_greater,
  output logic                  rsp_b_greater,
  output logic                  rsp_equal,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, COMPARE, RESPOND} state_t;
  state_t state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d, id_q, id_d, sel, idx;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic any;
  // Descending scan so the smallest offset from ptr wins.
  always_comb begin
    any = |req_valid;
    sel = '0;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr_q + ID_W'(k);
      if (req_valid[idx]) sel = idx;
    end
  end
  assign req_ready = (rst_n && state_q == IDLE && any) ? NUM_REQ'(1) << sel : '0;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    id_d = id_q;
    a_d = a_q;
    b_d = b_q;
    gt_d = gt_q;
    lt_d = lt_q;
    eq_d = eq_q;
    case (state_q)
      IDLE: if (any) begin
        state_d = COMPARE;
        id_d = sel;
        a_d = req_a[sel*W +: W];
        b_d = req_b[sel*W +: W];
      end
      COMPARE: begin
        gt_d = a_q > b_q;
        lt_d = a_q < b_q;
        eq_d = a_q == b_q;
        state_d = RESPOND;
      end
      RESPOND: if (rsp_ready) begin
        state_d = IDLE;
        ptr_d = id_q + ID_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q <= '0;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      gt_q <= 1'b0;
      lt_q <= 1'b0;
      eq_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      id_q <= id_d;
      a_q <= a_d;
      b_q <= b_d;
      gt_q <= gt_d;
      lt_q <= lt_d;
      eq_q <= eq_d;
    end
  end
  assign rsp_valid = state_q == RESPOND;
  assign busy = state_q != IDLE;
  assign rsp_id = id_q;
  assign rsp_a_greater = gt_q;
  assign rsp_b_greater = lt_q;
  assign rsp_equal = eq_q;
endmodule

// File: tb/tb_compare_arbiter.sv
// tb_compare_arbiter: directed and random transactions against a round-robin reference model.
module tb_compare_arbiter;
  localparam int N = 4;
  localparam int W = 2;
  logic clk = 0;
  logic rst_n = 0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic rsp_valid;
  logic rsp_ready = 0;
  logic [1:0] rsp_id;
  logic rsp_a_greater, rsp_b_greater, rsp_equal, busy;
  int vectors = 0;
  int miscompares = 0;
  int mptr = 0;

  compare_arbiter #(.NUM_REQ(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_a_greater(rsp_a_greater), .rsp_b_greater(rsp_b_greater),
    .rsp_equal(rsp_equal), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(mptr + k) % N]) return (mptr + k) % N;
    return 0;
  endfunction

  function automatic logic [10:0] outs();
    return {req_ready, rsp_valid, rsp_id, rsp_a_greater, rsp_b_greater, rsp_equal, busy};
  endfunction

  // One full transaction: grant, compare, respond after `hold` stalled cycles.
  task automatic txn(input logic [N-1:0] v, input logic [N*W-1:0] a, input logic [N*W-1:0] b,
                     input int hold);
    int s, ea, eb;
    logic [5:0] exp_rsp;
    req_valid = v;
    req_a = a;
    req_b = b;
    rsp_ready = 0;
    #1;
    s = pick(v);
    ea = int'(a[s*W +: W]);
    eb = int'(b[s*W +: W]);
    exp_rsp = {1'b1, 2'(s), ea > eb, eb > ea, ea == eb};
    chk("grant", req_ready, 32'(1) << s);
    tick;
    chk("compare_state", {busy, rsp_valid, req_ready}, {2'b10, 4'b0000});
    tick;
    chk("response", {rsp_valid, rsp_id, rsp_a_greater, rsp_b_greater, rsp_equal}, exp_rsp);
    chk("respond_busy", {busy, req_ready}, {1'b1, 4'b0000});
    for (int i = 0; i < hold; i++) begin
      tick;
      chk("stall_hold", {rsp_valid, rsp_id, rsp_a_greater, rsp_b_greater, rsp_equal, req_ready},
          {exp_rsp, 4'b0000});
    end
    rsp_ready = 1;
    tick;
    mptr = (s + 1) % N;
    chk("back_idle", {busy, rsp_valid}, 2'b00);
  endtask

  initial begin
    logic [N*W-1:0] a, b;
    for (int i = 0; i < 4; i++) begin
      req_valid = N'($urandom);
      req_a = (N*W)'($urandom);
      req_b = (N*W)'($urandom);
      rsp_ready = 1'($urandom);
      #7;
      chk("reset_outs", outs(), '0);
    end
    @(negedge clk);
    rst_n = 1;
    req_valid = '0;
    rsp_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("idle_no_req", {req_ready, busy, rsp_valid}, '0);
    end
    a = '0;
    b = '0;
    a[2*W +: W] = 2'd3;
    b[2*W +: W] = 2'd1;
    txn(4'b0100, a, b, 0);
    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++) begin
        a = (N*W)'($urandom);
        b = (N*W)'($urandom);
        a[0 +: W] = W'(x);
        b[0 +: W] = W'(y);
        txn(4'b0001, a, b, 0);
      end
    for (int i = 0; i < 8; i++) txn(4'b1111, (N*W)'($urandom), (N*W)'($urandom), 0);
    txn(4'($urandom_range(1, 15)), (N*W)'($urandom), (N*W)'($urandom), 5);
    for (int i = 0; i < 25; i++)
      txn(4'($urandom_range(1, 15)), (N*W)'($urandom), (N*W)'($urandom), $urandom_range(0, 2));
    txn(4'b0010, (N*W)'($urandom), (N*W)'($urandom), 0);
    req_valid = 4'b1111;
    rsp_ready = 1;
    tick;
    chk("pre_reset_compare", {busy, rsp_valid}, 2'b10);
    rst_n = 0;
    #1;
    chk("mid_reset_outs", outs(), '0);
    mptr = 0;
    tick;
    chk("reset_held", outs(), '0);
    @(negedge clk);
    rst_n = 1;
    txn(4'b1111, (N*W)'($urandom), (N*W)'($urandom), 0);
    req_valid = '0;
    tick;
    chk("final_idle", {req_ready, busy, rsp_valid}, '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
